// File: rtl/hba_gpio_in_cond_if.sv
// hba_gpio_in_cond_if: pad-side inputs, config and conditioned outputs of the GPIO input stage
interface hba_gpio_in_cond_if #(
    parameter int NUM_PINS     = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int GLITCH_WIDTH = 8
);
    logic [NUM_PINS-1:0]     pin_raw;
    logic [CNT_WIDTH-1:0]    hold_cycles;
    logic                    glitch_clr;
    logic [NUM_PINS-1:0]     pin_clean;
    logic [NUM_PINS-1:0]     pin_rise;
    logic [NUM_PINS-1:0]     pin_fall;
    logic                    change_any;
    logic [GLITCH_WIDTH-1:0] glitch_count;

    modport master (
        output pin_raw, hold_cycles, glitch_clr,
        input  pin_clean, pin_rise, pin_fall, change_any, glitch_count
    );
    modport slave (
        input  pin_raw, hold_cycles, glitch_clr,
        output pin_clean, pin_rise, pin_fall, change_any, glitch_count
    );
endinterface

// File: rtl/hba_gpio_in_cond.sv
// hba_gpio_in_cond: synchronise and debounce pad inputs, with edge strobes and a glitch counter
module hba_gpio_in_cond #(
    parameter int NUM_PINS     = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int GLITCH_WIDTH = 8
) (
    input logic               hba_clk,
    input logic               hba_reset,
    hba_gpio_in_cond_if.slave bus
);
    logic [NUM_PINS-1:0]     s1, s2, clean, rise, fall, commit, glitch;
    logic [CNT_WIDTH-1:0]    h_m1;
    logic [GLITCH_WIDTH-1:0] gcnt;
    logic                    chg;

    // hold of 0 behaves as 1; >= compare lets a lowered hold commit a pending count
    assign h_m1 = (bus.hold_cycles == '0) ? '0 : bus.hold_cycles - CNT_WIDTH'(1);

    always_ff @(posedge hba_clk or negedge hba_reset)
        if (!hba_reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.pin_raw;
            s2 <= s1;
        end

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        logic [CNT_WIDTH-1:0] cnt;
        logic                 mis;
        assign mis       = s2[i] ^ clean[i];
        assign commit[i] = mis && cnt >= h_m1;
        assign glitch[i] = !mis && cnt != '0;
        always_ff @(posedge hba_clk or negedge hba_reset)
            if (!hba_reset)
                cnt <= '0;
            else
                cnt <= (commit[i] || glitch[i]) ? '0 : mis ? cnt + CNT_WIDTH'(1) : cnt;
    end

    always_ff @(posedge hba_clk or negedge hba_reset)
        if (!hba_reset) begin
            clean <= '0;
            rise  <= '0;
            fall  <= '0;
            chg   <= 1'b0;
            gcnt  <= '0;
        end else begin
            clean <= clean ^ commit;
            rise  <= commit & ~clean;
            fall  <= commit & clean;
            chg   <= |commit;
            gcnt  <= bus.glitch_clr ? '0 : (|glitch && !(&gcnt)) ? gcnt + GLITCH_WIDTH'(1) : gcnt;
        end

    assign bus.pin_clean    = clean;
    assign bus.pin_rise     = rise;
    assign bus.pin_fall     = fall;
    assign bus.change_any   = chg;
    assign bus.glitch_count = gcnt;
endmodule

// File: tb/tb_hba_gpio_in_cond.sv
// tb_hba_gpio_in_cond: directed and random stimulus checked every cycle against a streak-based model
module tb_hba_gpio_in_cond;
    logic hba_clk = 1'b0;
    logic hba_reset = 1'b0;
    always #5 hba_clk = ~hba_clk;

    hba_gpio_in_cond_if bus ();
    hba_gpio_in_cond dut (.hba_clk(hba_clk), .hba_reset(hba_reset), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: pad samples pass through a two-deep delay queue; each pin tracks how many
    // consecutive cycles its synced level has disagreed with the clean level
    logic [3:0] dly [$];
    int         streak [4];
    logic [3:0] m_clean, m_rise, m_fall;
    logic       m_chg;
    int         m_gc;

    task automatic model_edge();
        logic [3:0] sv;
        int h;
        bit any_g;
        if (!hba_reset) begin
            dly = {};
            dly.push_back(4'h0);
            dly.push_back(4'h0);
            foreach (streak[i]) streak[i] = 0;
            m_clean = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0; m_gc = 0;
            return;
        end
        sv = dly.pop_front();
        dly.push_back(bus.pin_raw);
        h = (bus.hold_cycles == 0) ? 1 : int'(bus.hold_cycles);
        m_rise = '0; m_fall = '0; any_g = 0;
        for (int i = 0; i < 4; i++) begin
            if (sv[i] != m_clean[i]) begin
                if (streak[i] + 1 >= h) begin
                    m_rise[i] = sv[i];
                    m_fall[i] = !sv[i];
                    m_clean[i] = sv[i];
                    streak[i] = 0;
                end else
                    streak[i]++;
            end else begin
                if (streak[i] > 0) any_g = 1;
                streak[i] = 0;
            end
        end
        m_chg = |(m_rise | m_fall);
        m_gc = bus.glitch_clr ? 0 : any_g ? ((m_gc >= 255) ? 255 : m_gc + 1) : m_gc;
    endtask

    task automatic tick();
        @(posedge hba_clk);
        model_edge();
        #1;
        chk("clean", bus.pin_clean, m_clean);
        chk("rise", bus.pin_rise, m_rise);
        chk("fall", bus.pin_fall, m_fall);
        chk("change_any", bus.change_any, m_chg);
        chk("glitch_count", bus.glitch_count, m_gc);
    endtask

    task automatic bounce();
        bus.pin_raw = 4'b0100;
        repeat (4) tick();
        bus.pin_raw = 4'b0000;
        repeat (4) tick();
    endtask

    int gc_save;

    initial begin
        bus.pin_raw = 4'b1010;
        bus.hold_cycles = 16'd3;
        bus.glitch_clr = 1'b0;
        repeat (3) tick();
        chk("rst_clean", bus.pin_clean, 0);
        chk("rst_gc", bus.glitch_count, 0);
        hba_reset = 1'b1;
        repeat (4) tick();
        chk("rst_pre_commit", bus.pin_clean, 0);
        tick();
        chk("rst_commit", bus.pin_clean, 4'b1010);
        chk("rst_rise", bus.pin_rise, 4'b1010);
        tick();
        chk("rst_rise_once", bus.pin_rise, 0);

        for (int hv = 0; hv < 2; hv++) begin
            bus.hold_cycles = 16'(hv);
            bus.pin_raw = 4'b0000;
            repeat (8) tick();
            bus.pin_raw = 4'b0001;
            repeat (2) tick();
            chk("lat_early", bus.pin_clean, 0);
            tick();
            chk("lat_clean", bus.pin_clean, 4'b0001);
            chk("lat_rise", bus.pin_rise, 4'b0001);
        end

        bus.pin_raw = 4'b0000;
        repeat (6) tick();
        bus.hold_cycles = 16'd10;
        bus.glitch_clr = 1'b1;
        tick();
        bus.glitch_clr = 1'b0;
        bounce();
        chk("bounce_gc", bus.glitch_count, 1);
        chk("bounce_clean", bus.pin_clean, 0);
        repeat (299) bounce();
        chk("bounce_sat", bus.glitch_count, 255);

        bus.glitch_clr = 1'b1;
        tick();
        bus.glitch_clr = 1'b0;
        repeat (5) bounce();
        chk("clr_gc5", bus.glitch_count, 5);
        bus.pin_raw = 4'b0100;
        repeat (4) tick();
        bus.pin_raw = 4'b0000;
        repeat (2) tick();
        bus.glitch_clr = 1'b1;
        tick();
        bus.glitch_clr = 1'b0;
        chk("clr_priority", bus.glitch_count, 0);
        tick();
        bounce();
        chk("clr_then_one", bus.glitch_count, 1);

        bus.hold_cycles = 16'd2;
        bus.pin_raw = 4'b1111;
        repeat (3) tick();
        chk("multi_early", bus.pin_rise, 0);
        tick();
        chk("multi_clean", bus.pin_clean, 4'b1111);
        chk("multi_rise", bus.pin_rise, 4'b1111);
        chk("multi_chg", bus.change_any, 1);
        tick();
        chk("multi_chg_once", bus.change_any, 0);
        bus.pin_raw = 4'b0011;
        repeat (4) tick();
        chk("multi_fall", bus.pin_fall, 4'b1100);
        chk("multi_no_rise", bus.pin_rise, 0);

        bus.hold_cycles = 16'd1;
        bus.pin_raw = 4'b0000;
        repeat (5) tick();
        bus.hold_cycles = 16'd100;
        bus.pin_raw = 4'b0010;
        repeat (50) tick();
        chk("lower_pending", bus.pin_clean, 0);
        gc_save = m_gc;
        bus.hold_cycles = 16'd20;
        tick();
        chk("lower_commit", bus.pin_clean, 4'b0010);
        chk("lower_rise", bus.pin_rise, 4'b0010);
        chk("lower_no_glitch", bus.glitch_count, gc_save);

        repeat (4000) begin
            if ($urandom_range(0, 3) == 0) bus.pin_raw = 4'($urandom);
            if ($urandom_range(0, 49) == 0) bus.hold_cycles = 16'($urandom_range(0, 6));
            bus.glitch_clr = ($urandom_range(0, 40) == 0);
            hba_reset = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
